// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one double-precision FPU among NUM_REQ requesters
module fpu_share_arbiter #(
   parameter int         NUM_REQ       = 4,
   parameter logic [1:0] ROUND_MODE    = 2'b00,
   parameter int         SETTLE_CYCLES = 3,
   parameter int         TIMEOUT       = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [3*NUM_REQ-1:0]  req_op,
   input  logic [64*NUM_REQ-1:0] req_opa,
   input  logic [64*NUM_REQ-1:0] req_opb,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    done,
   output logic [63:0]           result,
   output logic [4:0]            flags,
   output logic                  err,
   output logic                  busy,
   output logic                  fpu_enable,
   output logic [2:0]            fpu_op,
   output logic [63:0]           fpu_opa,
   output logic [63:0]           fpu_opb,
   output logic [1:0]            fpu_rmode,
   input  logic [63:0]           fpu_out,
   input  logic                  fpu_ready,
   input  logic                  fpu_underflow,
   input  logic                  fpu_overflow,
   input  logic                  fpu_inexact,
   input  logic                  fpu_exception,
   input  logic                  fpu_invalid
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE, S_RESP} state_t;
   state_t             state_q;
   logic [IW-1:0]      rr_q, owner_q, sel, idx;
   logic               sel_v, ready_q, en_q, err_q, perr_q;
   logic [2:0]         sel_op, op_q;
   logic [63:0]        sel_a, sel_b, opa_q, opb_q, result_q, pres_q;
   logic [4:0]         flags_q, pflg_q;
   logic [NUM_REQ-1:0] gnt_q, done_q;
   logic [15:0]        tmo_q;
   logic [3:0]         cnt_q;
   logic               rise;
   assign rise       = fpu_ready & ~ready_q;
   assign gnt        = gnt_q;
   assign done       = done_q;
   assign result     = result_q;
   assign flags      = flags_q;
   assign err        = err_q;
   assign busy       = (state_q != S_IDLE);
   assign fpu_enable = en_q;
   assign fpu_op     = op_q;
   assign fpu_opa    = opa_q;
   assign fpu_opb    = opb_q;
   assign fpu_rmode  = ROUND_MODE;
   // pick the first requester after the last owner, nearest candidate wins
   always_comb begin
      sel   = '0;
      sel_v = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IW'((int'(rr_q) + k) % NUM_REQ);
         if (req[idx]) begin
            sel   = idx;
            sel_v = 1'b1;
         end
      end
   end
   // route the selected requester's opcode and operands
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IW'(i)) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_opa[64*i +: 64];
            sel_b  = req_opb[64*i +: 64];
         end
      end
   end
   // arbitration FSM; results are staged in pres/pflg/perr so outputs change only with done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         rr_q     <= IW'(NUM_REQ - 1);
         owner_q  <= '0;
         ready_q  <= 1'b0;
         en_q     <= 1'b0;
         op_q     <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
         pres_q   <= '0;
         pflg_q   <= '0;
         perr_q   <= 1'b0;
         tmo_q    <= '0;
         cnt_q    <= '0;
      end else begin
         ready_q <= fpu_ready;
         gnt_q   <= '0;
         done_q  <= '0;
         case (state_q)
            S_IDLE: if (sel_v) begin
               gnt_q[sel] <= 1'b1;
               owner_q    <= sel;
               op_q       <= sel_op;
               opa_q      <= sel_a;
               opb_q      <= sel_b;
               tmo_q      <= '0;
               if (sel_op <= 3'b011) begin
                  en_q    <= 1'b1;
                  state_q <= S_WAIT;
               end else begin
                  perr_q  <= 1'b1;
                  pres_q  <= '0;
                  pflg_q  <= '0;
                  state_q <= S_RESP;
               end
            end
            S_WAIT: if (rise) begin
               en_q    <= 1'b0;
               cnt_q   <= 4'(SETTLE_CYCLES);
               state_q <= S_SETTLE;
            end else if (tmo_q == 16'(TIMEOUT - 1)) begin
               en_q    <= 1'b0;
               perr_q  <= 1'b1;
               pres_q  <= '0;
               pflg_q  <= '0;
               state_q <= S_RESP;
            end else begin
               tmo_q <= tmo_q + 16'd1;
            end
            S_SETTLE: if (cnt_q == 4'd1) begin
               pres_q  <= fpu_out;
               pflg_q  <= {fpu_invalid, fpu_exception, fpu_inexact, fpu_overflow, fpu_underflow};
               perr_q  <= 1'b0;
               state_q <= S_RESP;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            S_RESP: begin
               done_q[owner_q] <= 1'b1;
               result_q        <= pres_q;
               flags_q         <= pflg_q;
               err_q           <= perr_q;
               rr_q            <= owner_q;
               state_q         <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed and randomized checks of the shared-FPU arbiter against a behavioural model
module tb_fpu_share_arbiter;
   localparam int N  = 4;
   localparam int SC = 3;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0]    req_m;
   logic [2:0]      r_op [N];
   logic [63:0]     r_a  [N];
   logic [63:0]     r_b  [N];
   logic [3*N-1:0]  req_op;
   logic [64*N-1:0] req_opa, req_opb;
   logic [N-1:0]    gnt, done;
   logic [63:0]     result;
   logic [4:0]      flags;
   logic            err, busy, fpu_enable;
   logic [2:0]      fpu_op;
   logic [63:0]     fpu_opa, fpu_opb;
   logic [1:0]      fpu_rmode;
   logic [63:0]     fpu_out = 64'd0;
   logic            fpu_ready = 1'b0;
   logic            fpu_underflow, fpu_overflow, fpu_inexact, fpu_exception, fpu_invalid;
   int              checks = 0, failures = 0;
   int              last = N - 1, lat = 1, cnt = 0, en_cnt = 0;
   bit              sticky = 1'b0, never = 1'b0;

   fpu_share_arbiter #(.NUM_REQ(N), .ROUND_MODE(2'b00), .SETTLE_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req_m), .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb),
      .gnt(gnt), .done(done), .result(result), .flags(flags), .err(err), .busy(busy),
      .fpu_enable(fpu_enable), .fpu_op(fpu_op), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
      .fpu_rmode(fpu_rmode), .fpu_out(fpu_out), .fpu_ready(fpu_ready),
      .fpu_underflow(fpu_underflow), .fpu_overflow(fpu_overflow), .fpu_inexact(fpu_inexact),
      .fpu_exception(fpu_exception), .fpu_invalid(fpu_invalid)
   );

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign req_op[3*i +: 3]   = r_op[i];
      assign req_opa[64*i +: 64] = r_a[i];
      assign req_opb[64*i +: 64] = r_b[i];
   end

   assign {fpu_invalid, fpu_exception, fpu_inexact, fpu_overflow, fpu_underflow} = fpu_out[4:0];

   function automatic logic [63:0] ref_fp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      real x, y;
      x = $bitstoreal(a);
      y = $bitstoreal(b);
      case (op)
         3'd0:    return $realtobits(x + y);
         3'd1:    return $realtobits(x - y);
         3'd2:    return $realtobits(x * y);
         3'd3:    return $realtobits(x / y);
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] rnd_val();
      return $realtobits(real'($urandom_range(1, 4000)) / 16.0);
   endfunction

   function automatic int pick(input logic [N-1:0] m);
      for (int k = 1; k <= N; k++)
         if (((m >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
      return 0;
   endfunction

   // FPU model: ready rises lat+1 enabled cycles after enable, after forcing a low cycle so a stale high is broken
   always @(posedge clk) begin
      if (!fpu_enable) begin
         cnt <= 0;
         if (!sticky) fpu_ready <= 1'b0;
      end else begin
         en_cnt <= en_cnt + 1;
         if (!never) begin
            cnt <= cnt + 1;
            if (cnt == lat) fpu_ready <= 1'b0;
            else if (cnt == lat + 1) begin
               fpu_ready <= 1'b1;
               fpu_out   <= ref_fp(fpu_op, fpu_opa, fpu_opb);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic txn(input string tag, input bit drop, input bit tmo);
      int w, gn, dn, edn;
      logic ill;
      logic [63:0] er;
      w   = pick(req_m);
      ill = (r_op[w] > 3'd3);
      er  = (ill || tmo) ? 64'd0 : ref_fp(r_op[w], r_a[w], r_b[w]);
      edn = ill ? 1 : tmo ? TO + 1 : lat + SC + 4;
      gn  = 0;
      do begin @(negedge clk); gn++; end while (gnt == '0 && gn < 20);
      chk({tag, "_gnt"}, 64'(gnt), 64'(N'(1) << w));
      chk({tag, "_gnt_lat"}, 64'(gn), 64'd1);
      chk({tag, "_en"}, 64'(fpu_enable), 64'(!ill));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      last = w;
      if (drop) req_m = req_m & ~(N'(1) << w);
      dn = 0;
      do begin @(negedge clk); dn++; end while (done == '0 && dn < 80);
      chk({tag, "_done"}, 64'(done), 64'(N'(1) << w));
      chk({tag, "_done_lat"}, 64'(dn), 64'(edn));
      chk({tag, "_result"}, result, er);
      chk({tag, "_flags"}, 64'(flags), 64'(er[4:0]));
      chk({tag, "_err"}, 64'(err), 64'(ill | tmo));
   endtask

   initial begin
      int dc, base;
      logic [63:0] one, two;
      one = 64'h3FF0000000000000;
      two = 64'h4000000000000000;
      req_m = '0;
      for (int i = 0; i < N; i++) begin
         r_op[i] = 3'd0;
         r_a[i]  = 64'd0;
         r_b[i]  = 64'd0;
      end
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_en", 64'(fpu_enable), 64'd0);
      chk("rst_op", 64'(fpu_op), 64'd0);
      chk("rst_opa", fpu_opa, 64'd0);
      chk("rst_opb", fpu_opb, 64'd0);
      chk("rst_rmode", 64'(fpu_rmode), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      // round robin from reset: all requesters hold add 1.0+1.0
      for (int i = 0; i < N; i++) begin
         r_op[i] = 3'd0;
         r_a[i]  = one;
         r_b[i]  = one;
      end
      req_m = 4'b1111;
      lat   = 1;
      for (int t = 0; t < 5; t++) begin
         txn($sformatf("rr%0d", t), 1'b0, 1'b0);
         chk($sformatf("rr%0d_two", t), result, two);
      end
      req_m = '0;
      // single multiply 1.0*2.0
      r_op[0] = 3'd2;
      r_a[0]  = one;
      r_b[0]  = two;
      req_m   = 4'b0001;
      lat     = 3;
      txn("single", 1'b1, 1'b0);
      chk("single_two", result, two);
      @(negedge clk);
      chk("single_pulse", 64'(done), 64'd0);
      chk("single_hold", result, two);
      // random single-requester legal ops
      for (int t = 0; t < 6; t++) begin
         int w;
         w = $urandom_range(0, N - 1);
         r_op[w] = 3'($urandom_range(0, 3));
         r_a[w]  = rnd_val();
         r_b[w]  = rnd_val();
         lat     = $urandom_range(0, 6);
         req_m   = N'(1) << w;
         txn($sformatf("solo%0d", t), 1'b1, 1'b0);
      end
      // illegal opcode never enables the FPU
      base    = en_cnt;
      r_op[2] = 3'b101;
      req_m   = 4'b0100;
      txn("illegal", 1'b1, 1'b0);
      chk("illegal_noen", 64'(en_cnt - base), 64'd0);
      // stale ready: A leaves ready high, B must wait for a fresh rising edge
      sticky  = 1'b1;
      r_op[1] = 3'd0;
      r_a[1]  = rnd_val();
      r_b[1]  = rnd_val();
      lat     = 2;
      req_m   = 4'b0010;
      txn("staleA", 1'b1, 1'b0);
      r_op[2] = 3'd1;
      r_a[2]  = rnd_val();
      r_b[2]  = rnd_val();
      lat     = 4;
      req_m   = 4'b0100;
      txn("staleB", 1'b1, 1'b0);
      sticky  = 1'b0;
      @(negedge clk);
      // timeout, then normal service
      never   = 1'b1;
      r_op[3] = 3'd0;
      req_m   = 4'b1000;
      txn("tmo", 1'b1, 1'b1);
      chk("tmo_en_low", 64'(fpu_enable), 64'd0);
      never   = 1'b0;
      r_op[0] = 3'd3;
      r_a[0]  = rnd_val();
      r_b[0]  = rnd_val();
      lat     = 2;
      req_m   = 4'b0001;
      txn("post_tmo", 1'b1, 1'b0);
      // asynchronous reset in the middle of WAIT
      never   = 1'b1;
      r_op[1] = 3'd2;
      req_m   = 4'b0010;
      @(negedge clk);
      chk("arst_gnt", 64'(gnt), 64'b0010);
      req_m = '0;
      repeat (3) @(negedge clk);
      chk("arst_pre_en", 64'(fpu_enable), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_en", 64'(fpu_enable), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_gnt0", 64'(gnt), 64'd0);
      last = N - 1;
      repeat (2) @(negedge clk);
      never = 1'b0;
      rst   = 1'b1;
      dc    = 0;
      repeat (20) begin
         @(negedge clk);
         if (done != '0) dc++;
      end
      chk("arst_nodone", 64'(dc), 64'd0);
      for (int i = 0; i < N; i++) begin
         r_op[i] = 3'd0;
         r_a[i]  = rnd_val();
         r_b[i]  = rnd_val();
      end
      req_m = 4'b1111;
      lat   = 1;
      txn("arst_first", 1'b1, 1'b0);
      chk("arst_first_owner0", 64'(last), 64'd0);
      // random contention with occasional illegal opcodes
      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < N; i++) begin
            if (((req_m >> i) & N'(1)) == '0 && $urandom_range(0, 1) == 1) begin
               r_op[i] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
               r_a[i]  = rnd_val();
               r_b[i]  = rnd_val();
               req_m   = req_m | (N'(1) << i);
            end
         end
         if (req_m == '0) begin
            r_op[0] = 3'd0;
            req_m   = 4'b0001;
         end
         lat = $urandom_range(0, 6);
         txn($sformatf("mix%0d", t), 1'b1, 1'b0);
      end
      req_m = '0;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
